// File: rtl/eeprom_spi_reader.sv
// eeprom_spi_reader: SPI mode-0 initiator that requests the shared EEPROM bus,
// drives CSf/sel_f toward the chip-select mux, issues READ + 16-bit address and
// streams the returned bytes out on a valid/ready interface.
// Build option: define EEPROM_FAST_READ_EN to use opcode 0x0B followed by one
// dummy byte before the data phase.
module eeprom_spi_reader #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       dev_sel,
    input  logic [15:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [1:0]       sel_f,
    output logic             CSf,
    output logic             sck,
    output logic             mosi,
    input  logic             miso
);

`ifdef EEPROM_FAST_READ_EN
    localparam logic [7:0]  OPCODE = 8'h0B;
    localparam int unsigned TX_W   = 32;
`else
    localparam logic [7:0]  OPCODE = 8'h03;
    localparam int unsigned TX_W   = 24;
`endif
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, REQ, CS_SETUP, CMD, ADDR, DUMMY, DATA, OUT, CS_HOLD, DONE
    } state_t;

    state_t            state;
    logic [7:0]        div_cnt;
    logic [4:0]        bit_cnt;
    logic [TX_W-1:0]   tx_sr;
    logic [7:0]        rx_sr;
    logic [LEN_W-1:0]  remaining;
    logic              phase_end;
    logic [4:0]        last_bit;

    assign phase_end = (div_cnt == DIV_LAST);

    // index of the final bit in the current shift state
    always_comb begin
        last_bit = 5'd7;
        if (state == ADDR) last_bit = 5'd15;
    end

    // transfer sequencer with registered SPI, handshake and bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            bus_req   <= 1'b0;
            sel_f     <= '0;
            CSf       <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= REQ;
                            busy      <= 1'b1;
                            bus_req   <= 1'b1;
                            sel_f     <= dev_sel;
                            remaining <= len;
                            tx_sr     <= TX_W'({OPCODE, addr}) << (TX_W - 24);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        state   <= CS_SETUP;
                        CSf     <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                CS_SETUP: begin
                    if (phase_end) begin
                        state   <= CMD;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        mosi    <= tx_sr[TX_W-1];
                        tx_sr   <= {tx_sr[TX_W-2:0], 1'b0};
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                            if (state == DATA) rx_sr <= {rx_sr[6:0], miso};
                        end else begin
                            // falling edge closes the bit; the next bit goes out now
                            sck   <= 1'b0;
                            mosi  <= tx_sr[TX_W-1];
                            tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= '0;
                                case (state)
                                    CMD:   state <= ADDR;
`ifdef EEPROM_FAST_READ_EN
                                    ADDR:  state <= DUMMY;
`else
                                    ADDR:  state <= DATA;
`endif
                                    DUMMY: state <= DATA;
                                    default: begin
                                        state    <= OUT;
                                        rd_data  <= rx_sr;
                                        rd_valid <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                OUT: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        remaining <= remaining - LEN_W'(1);
                        div_cnt   <= '0;
                        // remaining != 1 is the same test as (remaining - 1) != 0
                        if (remaining != LEN_W'(1)) state <= DATA;
                        else                        state <= CS_HOLD;
                    end
                end
                CS_HOLD: begin
                    if (phase_end) begin
                        state   <= DONE;
                        CSf     <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        bus_req <= 1'b0;
                        sel_f   <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_spi_reader.sv
// tb_eeprom_spi_reader: self-checking bench with an EEPROM slave model that
// decodes the header from mosi and answers on miso; expected bytes are queued
// when a read is issued and popped on each rd_valid/rd_ready handshake.
module tb_eeprom_spi_reader;

    localparam int LEN_W = 8;
`ifdef EEPROM_FAST_READ_EN
    localparam int         HDR    = 32;
    localparam logic [7:0] EXP_OP = 8'h0B;
`else
    localparam int         HDR    = 24;
    localparam logic [7:0] EXP_OP = 8'h03;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       dev_sel;
    logic [15:0]      addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             bus_req;
    logic             bus_gnt;
    logic [1:0]       sel_f;
    logic             CSf;
    logic             sck;
    logic             mosi;
    logic             miso;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] hdr_sr = '0;
    int          rise_cnt = 0;
    int          sck_rises = 0;
    int          data_mosi_err = 0;

    eeprom_spi_reader #(.CLK_DIV(4), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .dev_sel(dev_sel), .addr(addr),
        .len(len), .busy(busy), .done(done), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .sel_f(sel_f), .CSf(CSf), .sck(sck),
        .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // EEPROM contents
    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h1235: return 8'h5A;
            16'h1236: return 8'hFF;
            default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
        endcase
    endfunction

    function automatic logic rom_bit(input int cnt, input logic [31:0] h);
        int          k;
        logic [15:0] a;
        logic [7:0]  b;
        if (cnt < HDR) return 1'b0;
        k = cnt - HDR;
        a = (HDR == 32) ? h[23:8] : h[15:0];
        b = rom(a + 16'(k / 8));
        return b[3'(7 - k % 8)];
    endfunction

    // slave model: header capture on sck rise, restart on CSf fall
    always @(negedge CSf or posedge sck) begin
        if (sck) begin
            if (rise_cnt < HDR) hdr_sr = {hdr_sr[30:0], mosi};
            else if (mosi) data_mosi_err++;
            rise_cnt++;
            sck_rises++;
        end else begin
            rise_cnt      = 0;
            hdr_sr        = '0;
            data_mosi_err = 0;
        end
    end

    assign miso = rom_bit(rise_cnt, hdr_sr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [1:0] dev, input logic [15:0] a, input int n,
                           input int gnt_dly, input int bp_byte, input int bp_cycles);
        int         rises0;
        int         byte_idx;
        int         hold;
        int         bp_err;
        int         sel_err;
        int         pre_err;
        bit         seen_done;
        logic       busy_at_done;
        logic [7:0] exp_b;
        byte_idx = 0; hold = 0; bp_err = 0; sel_err = 0; pre_err = 0;
        seen_done = 1'b0; busy_at_done = 1'b1;
        @(negedge clk);
        dev_sel = dev; addr = a; len = LEN_W'(n); start = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(rom(a + 16'(i)));
        rises0 = sck_rises;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("bus_req_after_start", 32'(bus_req), 1);
        for (int i = 0; i < gnt_dly; i++) begin
            if (CSf !== 1'b1 || sck !== 1'b0) pre_err++;
            @(negedge clk);
        end
        bus_gnt = 1'b1;
        for (int cyc = 0; cyc < 20000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen_done    = 1'b1;
                busy_at_done = busy;
            end else begin
                if (busy && sel_f !== dev) sel_err++;
                if (rd_valid && byte_idx == bp_byte && hold < bp_cycles) begin
                    rd_ready = 1'b0;
                    hold++;
                    if (sck !== 1'b0 || CSf !== 1'b0 || rd_data !== exp_q[0]) bp_err++;
                end else begin
                    rd_ready = 1'b1;
                end
                if (rd_valid && rd_ready) begin
                    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("rd_data", 32'(rd_data), 32'(exp_b));
                    end
                    byte_idx++;
                end
            end
        end
        check("done_seen", 32'(seen_done), 1);
        check("busy_at_done", 32'(busy_at_done), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("csf_after", 32'(CSf), 1);
        check("bus_req_after", 32'(bus_req), 0);
        check("sck_rises", 32'(sck_rises - rises0), 32'(HDR + 8 * n));
        check("opcode", 32'((HDR == 32) ? hdr_sr[31:24] : hdr_sr[23:16]), 32'(EXP_OP));
        check("address", 32'((HDR == 32) ? hdr_sr[23:8] : hdr_sr[15:0]), 32'(a));
        if (HDR == 32) check("dummy_byte", 32'(hdr_sr[7:0]), 0);
        check("mosi_in_data", 32'(data_mosi_err), 0);
        check("bytes_drained", 32'(exp_q.size()), 0);
        check("sel_f_err", 32'(sel_err), 0);
        check("pre_grant_err", 32'(pre_err), 0);
        if (bp_cycles > 0) begin
            check("bp_stall_err", 32'(bp_err), 0);
            check("bp_cycles", 32'(hold), 32'(bp_cycles));
        end
        exp_q.delete();
        bus_gnt  = 1'b0;
        rd_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  err;
        int  r0;
        bit  reached;
        rst = 1'b1; start = 1'b0; dev_sel = '0; addr = '0; len = '0;
        rd_ready = 1'b1; bus_gnt = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_csf", 32'(CSf), 1);
        check("rst_sck", 32'(sck), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_sel_f", 32'(sel_f), 0);
        check("rst_mosi", 32'(mosi), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;

        // basic read, then back-pressure on byte 1, then other patterns
        do_read(2'd2, 16'h1234, 3, 5, -1, 0);
        do_read(2'd2, 16'h1234, 3, 5, 1, 20);
        do_read(2'd1, 16'hFFFE, 4, 0, -1, 0);
        do_read(2'd3, 16'h00FF, 1, 2, 0, 3);

        // zero length: immediate done, no bus activity
        @(negedge clk);
        dev_sel = 2'd3; len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zl_done", 32'(done), 1);
        check("zl_busy", 32'(busy), 0);
        check("zl_bus_req", 32'(bus_req), 0);
        check("zl_csf", 32'(CSf), 1);
        @(negedge clk);
        check("zl_done_pulse", 32'(done), 0);
        check("zl_bus_req2", 32'(bus_req), 0);

        // withheld grant, ignored start while busy, async reset mid-ADDR
        dev_sel = 2'd1; addr = 16'hABCD; len = LEN_W'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_req !== 1'b1 || CSf !== 1'b1 || busy !== 1'b1) err++;
            dev_sel = 2'd3;
            start   = (i == 10);
            @(negedge clk);
        end
        start = 1'b0;
        check("req_hold_err", 32'(err), 0);
        check("ignored_start_sel", 32'(sel_f), 1);
        r0 = sck_rises;
        reached = 1'b0;
        bus_gnt = 1'b1;
        for (int cyc = 0; cyc < 5000 && !reached; cyc++) begin
            @(negedge clk);
            if (sck_rises - r0 >= 16) reached = 1'b1;
        end
        check("reach_addr", 32'(reached), 1);
        check("abort_pre_csf", 32'(CSf), 0);
        #1 rst = 1'b1;
        #1;
        check("abort_csf", 32'(CSf), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_sck", 32'(sck), 0);
        check("abort_bus_req", 32'(bus_req), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus_gnt = 1'b0;

        // recovery after abort
        do_read(2'd0, 16'h0000, 2, 1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eeprom_spi_reader.md
Name: eeprom_spi_reader

Overview:
- FPGA-side SPI initiator that drives the FPGA chip-select path (CSf, sel_f) into the EEPROM chip-select mux.
- Issues an EEPROM READ sequence (command, 16-bit address) to one of four serial EEPROMs and streams the returned bytes out on a valid/ready interface.
- Requests the shared EEPROM bus from the board arbiter before asserting CSf and releases it afterwards, so the microcontroller path is never overlapped.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal range 1..255.
- LEN_W, 8, width of the byte-count input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- dev_sel  in  2  target EEPROM index 0..3; latched at start
- addr  in  16  start byte address; latched at start
- len  in  LEN_W  number of bytes to read; latched at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at the end of a transfer
- rd_data  out  8  received byte
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- bus_req  out  1  EEPROM bus request to the arbiter
- bus_gnt  in  1  bus grant (arbiter drives sel1)
- sel_f  out  2  EEPROM select toward the chip-select mux; equals latched dev_sel while busy
- CSf  out  1  chip select, active-low; idle high
- sck  out  1  SPI clock, mode 0, idle low
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset values: CSf=1, sck=0, mosi=0, busy=0, done=0, rd_valid=0, rd_data=0, bus_req=0, sel_f=0. Reset mid-transfer forces these values immediately, because reset is asynchronous.
- States and transitions:
  - IDLE: start=1 with len≠0 → REQ. start=1 with len=0 → DONE, with no bus activity.
  - REQ: bus_req=1. On bus_gnt=1 → CS_SETUP. Grant is sampled only here; later deassertion of bus_gnt is ignored until release.
  - CS_SETUP: CSf=0 for CLK_DIV cycles with sck low, then → CMD.
  - CMD: shift 8 bits of opcode 0x03, MSB first → ADDR.
  - ADDR: shift 16 address bits, MSB first → DATA.
  - DATA: shift in 8 bits → OUT.
  - OUT: rd_valid=1 and sck held low. On rd_ready=1, decrement the remaining count: if remaining≠0 → DATA, else → CS_HOLD.
  - CS_HOLD: sck low and CSf=0 for CLK_DIV cycles, then CSf=1 → DONE.
  - DONE: done=1 for one cycle, bus_req=0, busy=0 → IDLE.
- Bit timing (mode 0):
  - Each bit is 2*CLK_DIV clk cycles: sck low for the first CLK_DIV, high for the second.
  - mosi updates at the start of the low phase.
  - miso is sampled on the clk edge where sck rises; shifted in MSB first.
- mosi is 0 during DATA.
- rd_data stays stable while rd_valid=1; it updates only on entry to OUT.
- Byte count: remaining counter is LEN_W bits wide; len=255 reads 255 bytes.
- start while busy is ignored.
- busy deasserts in the same cycle as the done pulse.

Optional Feature:
- Macro EEPROM_FAST_READ_EN.
- Defined: opcode is 0x0B, and a DUMMY state shifts 8 zero bits between ADDR and DATA (32 SCK cycles before the first data bit).
- Undefined: opcode 0x03, no dummy byte (24 SCK cycles before the first data bit).

Test Plan:
- Reset: assert rst for 3 cycles → CSf=1, sck=0, busy=0, rd_valid=0, bus_req=0, sel_f=0.
- Basic read: CLK_DIV=4, start with dev_sel=2, addr=0x1234, len=3; bus_gnt after 5 cycles; EEPROM model returns 0xA5, 0x5A, 0xFF; rd_ready=1.
  - mosi carries 0x03, 0x12, 0x34.
  - sel_f=2 throughout.
  - 48 sck rising edges.
  - rd_valid with the three bytes in order.
  - One done pulse, then CSf=1 and bus_req=0.
- Back-pressure: same read with rd_ready=0 for 20 cycles on byte 1 → sck stays low, CSf stays 0, rd_data=0x5A stays stable; the transfer resumes and completes after rd_ready=1.
- Zero length: start with len=0 → bus_req never asserts, CSf stays 1, done on the following cycle.
- Grant/abort: withhold bus_gnt → stays in REQ with CSf=1. Then grant, and assert rst mid-ADDR → CSf=1 and busy=0 asynchronously. A start pulse while busy (before the reset) is ignored.
- EEPROM_FAST_READ_EN build, basic read → mosi carries 0x0B, 0x12, 0x34, 0x00; 56 sck rising edges for 3 bytes.
